// File: rtl/lmsm_sequencer_pkg.sv
// lmsm_sequencer_pkg: shared state encoding and widths for the load/store-multiple sequencer
package lmsm_sequencer_pkg;
  localparam int ADDR_W = 16;
  localparam int MASK_W = 8;
  localparam logic MEM_WE_ACTIVE = 1'b0;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: request, register-file and data-memory signals of the sequencer
// slave: the sequencer (takes start/mask/base and read data, drives memory and register-file controls)
// master: the pipeline/environment side
interface lmsm_sequencer_if;
  import lmsm_sequencer_pkg::*;
  logic start;
  logic is_sm;
  logic [MASK_W-1:0] reg_mask;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0] rf_read_data;
  logic [15:0] mem_rdata;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_write;
  logic [15:0] mem_wdata;
  logic [2:0] rf_read_idx;
  logic rf_write_en;
  logic [2:0] rf_write_idx;
  logic [15:0] rf_write_data;
  modport slave (
    input start, is_sm, reg_mask, base_addr, rf_read_data, mem_rdata,
    output busy, done, mem_addr, mem_write, mem_wdata, rf_read_idx, rf_write_en, rf_write_idx, rf_write_data
  );
  modport master (
    output start, is_sm, reg_mask, base_addr, rf_read_data, mem_rdata,
    input busy, done, mem_addr, mem_write, mem_wdata, rf_read_idx, rf_write_en, rf_write_idx, rf_write_data
  );
endinterface

// File: rtl/lmsm_prio_enc.sv
// lmsm_prio_enc: index of the lowest set bit of the mask
// i_mask: mask in; o_idx: lowest set bit index (0 when empty); o_valid: mask non-zero
module lmsm_prio_enc
  import lmsm_sequencer_pkg::*;
(
  input  logic [MASK_W-1:0] i_mask,
  output logic [2:0]        o_idx,
  output logic              o_valid
);
  always_comb begin
    o_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) o_idx = i_mask[i] ? 3'(i) : o_idx;
  end
  assign o_valid = |i_mask;
endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: load/store-multiple sequencer moving one register per cycle in ascending order
// clk: clock; reset: synchronous active-low reset
// bus: request inputs, memory/register-file controls, busy stall and one-cycle done pulse
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  lmsm_sequencer_if.slave bus
);
  state_t r_state;
  logic r_is_sm;
  logic [MASK_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0] w_idx;
  logic w_valid;
  logic [MASK_W-1:0] w_rest;
  logic w_xfer, w_sm, w_lm;
  lmsm_prio_enc u_enc (.i_mask(r_mask), .o_idx(w_idx), .o_valid(w_valid));
  assign w_rest = r_mask & ~(MASK_W'(1) << w_idx);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_is_sm <= 1'b0;
      r_mask  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_is_sm <= bus.is_sm;
          r_mask  <= bus.reg_mask;
          r_addr  <= bus.base_addr;
          r_state <= (bus.reg_mask != '0) ? XFER : DONE;
        end
        XFER: begin
          r_mask  <= w_rest;
          r_addr  <= r_addr + ADDR_W'(1);
          r_state <= (w_rest == '0) ? DONE : XFER;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // reset gating keeps a mid-transfer abort from issuing a write in the cycle reset is asserted
  assign w_xfer = reset && (r_state == XFER) && w_valid;
  assign w_sm = w_xfer && r_is_sm;
  assign w_lm = w_xfer && !r_is_sm;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  assign bus.mem_addr = r_addr;
  assign bus.mem_write = w_sm ? MEM_WE_ACTIVE : ~MEM_WE_ACTIVE;
  assign bus.mem_wdata = w_sm ? bus.rf_read_data : '0;
  assign bus.rf_read_idx = w_sm ? w_idx : '0;
  assign bus.rf_write_en = w_lm;
  assign bus.rf_write_idx = w_lm ? w_idx : '0;
  assign bus.rf_write_data = w_lm ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: per-cycle directed vectors plus a busy/abort sequence for lmsm_sequencer
module tb_lmsm_sequencer;
  typedef struct {
    logic rst_n, start, is_sm;
    logic [7:0] mask;
    logic [15:0] base, rd, mr;
    logic busy, done, we_n, rfwe;
    logic [15:0] addr, wdata;
    logic [2:0] ridx, widx;
    logic [15:0] wd;
  } vec_t;
  logic clk, reset;
  int tests = 0, fails = 0;
  vec_t v[18];
  lmsm_sequencer_if bus();
  lmsm_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{1'b0,1'b1,1'b1,8'hFF,16'h1234,16'h9999,16'h8888, 1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'h0000};
    v[1]  = v[0];
    v[2]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'h0000};
    v[3]  = '{1'b1,1'b1,1'b0,8'h0C,16'h0010,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'h0000};
    v[4]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h1234, 1'b1,1'b0,1'b1,1'b1,16'h0010,16'h0000,3'd0,3'd2,16'h1234};
    v[5]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h5678, 1'b1,1'b0,1'b1,1'b1,16'h0011,16'h0000,3'd0,3'd3,16'h5678};
    v[6]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h5678, 1'b1,1'b1,1'b1,1'b0,16'h0012,16'h0000,3'd0,3'd0,16'h0000};
    v[7]  = '{1'b1,1'b1,1'b1,8'h81,16'h00FF,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0012,16'h0000,3'd0,3'd0,16'h0000};
    v[8]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'hAAAA,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h00FF,16'hAAAA,3'd0,3'd0,16'h0000};
    v[9]  = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'hBBBB,16'h0000, 1'b1,1'b0,1'b0,1'b0,16'h0100,16'hBBBB,3'd7,3'd0,16'h0000};
    v[10] = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'hBBBB,16'h0000, 1'b1,1'b1,1'b1,1'b0,16'h0101,16'h0000,3'd0,3'd0,16'h0000};
    v[11] = '{1'b1,1'b1,1'b0,8'h03,16'hFFFF,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0101,16'h0000,3'd0,3'd0,16'h0000};
    v[12] = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h1111, 1'b1,1'b0,1'b1,1'b1,16'hFFFF,16'h0000,3'd0,3'd0,16'h1111};
    v[13] = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h2222, 1'b1,1'b0,1'b1,1'b1,16'h0000,16'h0000,3'd0,3'd1,16'h2222};
    v[14] = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h2222, 1'b1,1'b1,1'b1,1'b0,16'h0001,16'h0000,3'd0,3'd0,16'h0000};
    v[15] = '{1'b1,1'b1,1'b1,8'h00,16'h0050,16'h7777,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0001,16'h0000,3'd0,3'd0,16'h0000};
    v[16] = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h7777,16'h0000, 1'b1,1'b1,1'b1,1'b0,16'h0050,16'h0000,3'd0,3'd0,16'h0000};
    v[17] = '{1'b1,1'b0,1'b0,8'h00,16'h0000,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,16'h0050,16'h0000,3'd0,3'd0,16'h0000};
    reset = 1'b0;
    bus.start = 1'b1;
    bus.is_sm = 1'b1;
    bus.reg_mask = 8'hFF;
    bus.base_addr = 16'h1234;
    bus.rf_read_data = 16'h9999;
    bus.mem_rdata = 16'h8888;
    tick();
    for (int i = 0; i < 18; i++) begin
      reset = v[i].rst_n;
      bus.start = v[i].start;
      bus.is_sm = v[i].is_sm;
      bus.reg_mask = v[i].mask;
      bus.base_addr = v[i].base;
      bus.rf_read_data = v[i].rd;
      bus.mem_rdata = v[i].mr;
      #1;
      chk($sformatf("r%0d busy", i), 16'(bus.busy), 16'(v[i].busy));
      chk($sformatf("r%0d done", i), 16'(bus.done), 16'(v[i].done));
      chk($sformatf("r%0d mem_write", i), 16'(bus.mem_write), 16'(v[i].we_n));
      chk($sformatf("r%0d rf_write_en", i), 16'(bus.rf_write_en), 16'(v[i].rfwe));
      chk($sformatf("r%0d mem_addr", i), bus.mem_addr, v[i].addr);
      chk($sformatf("r%0d mem_wdata", i), bus.mem_wdata, v[i].wdata);
      chk($sformatf("r%0d rf_read_idx", i), 16'(bus.rf_read_idx), 16'(v[i].ridx));
      chk($sformatf("r%0d rf_write_idx", i), 16'(bus.rf_write_idx), 16'(v[i].widx));
      chk($sformatf("r%0d rf_write_data", i), bus.rf_write_data, v[i].wd);
      tick();
    end
    bus.start = 1'b1;
    bus.is_sm = 1'b1;
    bus.reg_mask = 8'hFF;
    bus.base_addr = 16'h0200;
    bus.rf_read_data = 16'hC0DE;
    bus.mem_rdata = 16'h0000;
    tick();
    bus.is_sm = 1'b0;
    bus.reg_mask = 8'h00;
    bus.base_addr = 16'h0300;
    #1;
    chk("abort c1 addr", bus.mem_addr, 16'h0200);
    chk("abort c1 mem_write", 16'(bus.mem_write), 16'h0);
    chk("abort c1 ridx", 16'(bus.rf_read_idx), 16'h0);
    chk("abort c1 wdata", bus.mem_wdata, 16'hC0DE);
    tick();
    chk("abort c2 addr", bus.mem_addr, 16'h0201);
    chk("abort c2 ridx", 16'(bus.rf_read_idx), 16'h1);
    chk("abort c2 mem_write", 16'(bus.mem_write), 16'h0);
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("abort c3 mem_write gated", 16'(bus.mem_write), 16'h1);
    chk("abort c3 rf_write_en gated", 16'(bus.rf_write_en), 16'h0);
    chk("abort c3 busy", 16'(bus.busy), 16'h1);
    tick();
    chk("abort idle busy", 16'(bus.busy), 16'h0);
    chk("abort idle addr", bus.mem_addr, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("post abort %0d done", i), 16'(bus.done), 16'h0);
      chk($sformatf("post abort %0d busy", i), 16'(bus.busy), 16'h0);
      chk($sformatf("post abort %0d mem_write", i), 16'(bus.mem_write), 16'h1);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
